muldiv_ctrl: RTL and testbench
==============================

// Module: muldiv_ctrl
// PURPOSE
//  RV32M sequencer between the EX stage and the 32-bit unsigned multDiv unit (mode 0 multu, 1 divu).
//  Decodes funct3 and converts signed operands to magnitudes, then issues a single valid pulse to the unit.
//  Waits for ready, selects and sign-fixes the result, and returns one tagged response to writeback.
//  Handles divide-by-zero locally, and drains the unit on pipeline flush; the unit itself cannot be aborted.
// PARAMETERS
//  RD_W  5  width of destination-register tag carried from request to response
// PORTS
//  clk         in   1     clock, all state updates on rising edge
//  rst_n       in   1     asynchronous active-low reset
//  req_valid   in   1     M-op request
//  req_ready   out  1     1 only in IDLE; request accepted when req_valid & req_ready & !flush
//  req_funct3  in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  req_rs1     in   32    operand A (dividend / multiplicand)
//  req_rs2     in   32    operand B (divisor / multiplier)
//  req_rd      in   RD_W  destination tag
//  flush       in   1     kill in-flight op (pipeline redirect)
//  resp_valid  out  1     one-cycle pulse, result valid
//  resp_data   out  32    result
//  resp_rd     out  RD_W  tag of accepted request
//  md_valid    out  1     to unit: one-cycle start pulse
//  md_mode     out  1     to unit: 0 multu, 1 divu
//  md_in_A     out  32    to unit: |A|
//  md_in_B     out  32    to unit: |B|
//  md_ready    in   1     from unit: one-cycle done pulse
//  md_out      in   64    from unit: product, or {remainder[63:32], quotient[31:0]}
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except req_ready=1. Registers are async-cleared; the unit shares rst_n.
//  FSM states: IDLE, ISSUE, WAIT, DONE, DRAIN. All outputs are registered or decoded from state.
//  IDLE: on accept, latch funct3, rd, a_neg, b_neg, and magnitudes.
//   - a_neg = rs1[31] & (funct3 in MULH, MULHSU, DIV, REM).
//   - b_neg = rs2[31] & (funct3 in MULH, DIV, REM).
//   - |x| = neg ? (~x + 1) : x. 0x80000000 maps to itself and is treated as unsigned.
//   - DIV/DIVU/REM/REMU with rs2 == 0: go to DONE directly and never pulse md_valid.
//   - All other ops go to ISSUE.
//  ISSUE: md_valid = 1 for exactly this cycle; md_mode = funct3[2]; next state WAIT.
//   - md_in_A/B are held stable from ISSUE until md_ready.
//  WAIT: on md_ready, compute the result, register it into resp_data, and go to DONE.
//  Result computation:
//   - MUL ops: p = (a_neg ^ b_neg) ? (~md_out + 1) : md_out, negated over the full 64 bits.
//   - MUL returns p[31:0]; MULH, MULHSU and MULHU return p[63:32].
//   - DIV/DIVU: q = md_out[31:0], negated if a_neg ^ b_neg.
//   - REM/REMU: r = md_out[63:32], negated if a_neg (sign of the dividend).
//   - 0x80000000 / -1 therefore yields quotient 0x80000000 and remainder 0, with no special case.
//  Divide by zero: quotient = 0xFFFFFFFF; remainder = rs1 unmodified.
//  DONE: resp_valid = 1 for one cycle, with resp_data and resp_rd; next state IDLE.
//  Latency:
//   - Divide by zero: resp_valid is 1 cycle after accept.
//   - Otherwise: resp_valid = accept + 1 (ISSUE) + L_md + 1, where L_md = cycles from md_valid to md_ready (33 for the current unit).
//  Flush (priority over every other event):
//   - IDLE: request in the same cycle is not accepted.
//   - ISSUE: go to IDLE; md_valid is not asserted.
//   - WAIT: go to DRAIN.
//   - DONE: resp_valid is suppressed; go to IDLE.
//   - DRAIN: no effect.
//  DRAIN: req_ready = 0; wait for md_ready, discard md_out, go to IDLE. No response is issued.
//  md_ready seen outside WAIT/DRAIN is ignored. At most one op is in flight; no back-to-back issue without returning to IDLE.
//  Async reset mid-operation: immediate return to IDLE, outputs cleared, no response for the lost op.
// TESTING
//  MUL 0x00000007 x 0xFFFFFFFD:
//   -> md_in_A=7, md_in_B=3, md_mode=0, single md_valid pulse; resp_data=0xFFFFFFEB.
//  High-half multiplies:
//   -> MULH 0x80000000 x 0x80000000 = 0x40000000.
//   -> MULHU 0xFFFFFFFF x 0xFFFFFFFF = 0xFFFFFFFE.
//   -> MULHSU 0xFFFFFFFF x 0xFFFFFFFF = 0xFFFFFFFF.
//  Divides of -7 (0xFFFFFFF9) by 2:
//   -> DIV = 0xFFFFFFFD; REM = 0xFFFFFFFF.
//   -> DIVU 7/2 = 3; REMU 7/2 = 1; resp_rd echoes req_rd.
//  Divide by zero and overflow:
//   -> DIV 5/0 = 0xFFFFFFFF and REM 5/0 = 5, each 1 cycle after accept with no md_valid.
//   -> DIV 0x80000000/0xFFFFFFFF = 0x80000000; REM of the same = 0.
//  Flush 10 cycles after md_valid:
//   -> req_ready stays 0 until the cycle after md_ready; no resp_valid.
//   -> The next MUL 3x4 returns 12.
//   -> req_valid asserted together with flush in IDLE is not accepted.
//  rst_n pulsed low mid-WAIT:
//   -> outputs 0, req_ready=1 immediately; no resp_valid.
//   -> The following DIVU 100/7 returns 14.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: RV32M sequencer between the EX stage and an unsigned
// multiply/divide unit. Signed operands are reduced to magnitudes, the unit
// is started with a single pulse and the result is sign-fixed on return.
// Divide-by-zero is answered locally. A flushed op already running in the
// unit is drained, because the unit cannot be aborted.
//
// Handshakes:
//  - Request: accepted on a cycle with req_valid & req_ready & !flush.
//    req_ready is high only in IDLE.
//  - Unit: md_valid is a one-cycle start pulse. md_ready is a one-cycle done
//    pulse; it is only honoured in WAIT and DRAIN.
//  - Response: resp_valid is a one-cycle pulse and has no backpressure.
module muldiv_ctrl #(
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [31:0]     req_rs1,
    input  logic [31:0]     req_rs2,
    input  logic [RD_W-1:0] req_rd,
    input  logic            flush,
    output logic            resp_valid,
    output logic [31:0]     resp_data,
    output logic [RD_W-1:0] resp_rd,
    output logic            md_valid,
    output logic            md_mode,
    output logic [31:0]     md_in_A,
    output logic [31:0]     md_in_B,
    input  logic            md_ready,
    input  logic [63:0]     md_out,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic            a_neg_q, a_neg_d;
    logic            b_neg_q, b_neg_d;
    logic [31:0]     mag_a_q, mag_a_d;
    logic [31:0]     mag_b_q, mag_b_d;
    logic [31:0]     resp_data_q, resp_data_d;

    // Request decode
    logic        accept;
    logic        sgn_a_op;
    logic        sgn_b_op;
    logic        in_a_neg;
    logic        in_b_neg;
    logic        div_by_zero;
    logic [31:0] dz_result;

    // Result path
    logic        res_neg;
    logic [63:0] prod_fix;
    logic [31:0] mul_res;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] result;

    // Operand decode: sign handling per funct3 and the local divide-by-zero answer
    always_comb begin
        accept      = req_valid && (state_q == S_IDLE) && !flush;
        sgn_a_op    = (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                      (req_funct3 == 3'b100) || (req_funct3 == 3'b110);
        sgn_b_op    = (req_funct3 == 3'b001) || (req_funct3 == 3'b100) ||
                      (req_funct3 == 3'b110);
        in_a_neg    = req_rs1[31] && sgn_a_op;
        in_b_neg    = req_rs2[31] && sgn_b_op;
        div_by_zero = req_funct3[2] && (req_rs2 == 32'd0);
        // REM/REMU return the dividend untouched, DIV/DIVU return all ones
        dz_result   = req_funct3[1] ? req_rs1 : 32'hFFFF_FFFF;
    end

    // Result selection and sign fix from the unit's unsigned output
    always_comb begin
        res_neg  = a_neg_q ^ b_neg_q;
        prod_fix = res_neg ? (~md_out + 64'd1) : md_out;
        mul_res  = (funct3_q[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
        quo_fix  = res_neg ? (~md_out[31:0] + 32'd1) : md_out[31:0];
        // Remainder takes the sign of the dividend only
        rem_fix  = a_neg_q ? (~md_out[63:32] + 32'd1) : md_out[63:32];
        result   = funct3_q[2] ? (funct3_q[1] ? rem_fix : quo_fix) : mul_res;
    end

    // Next-state and datapath update; flush takes priority in every state
    always_comb begin
        state_d     = state_q;
        funct3_d    = funct3_q;
        rd_d        = rd_q;
        a_neg_d     = a_neg_q;
        b_neg_d     = b_neg_q;
        mag_a_d     = mag_a_q;
        mag_b_d     = mag_b_q;
        resp_data_d = resp_data_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    funct3_d = req_funct3;
                    rd_d     = req_rd;
                    a_neg_d  = in_a_neg;
                    b_neg_d  = in_b_neg;
                    mag_a_d  = in_a_neg ? (~req_rs1 + 32'd1) : req_rs1;
                    mag_b_d  = in_b_neg ? (~req_rs2 + 32'd1) : req_rs2;
                    if (div_by_zero) begin
                        resp_data_d = dz_result;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_d = flush ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (flush) begin
                    // If the unit finishes in the same cycle there is nothing
                    // left to drain, so go straight back to IDLE.
                    state_d = md_ready ? S_IDLE : S_DRAIN;
                end else if (md_ready) begin
                    resp_data_d = result;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (md_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            funct3_q    <= 3'd0;
            rd_q        <= '0;
            a_neg_q     <= 1'b0;
            b_neg_q     <= 1'b0;
            mag_a_q     <= 32'd0;
            mag_b_q     <= 32'd0;
            resp_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            funct3_q    <= funct3_d;
            rd_q        <= rd_d;
            a_neg_q     <= a_neg_d;
            b_neg_q     <= b_neg_d;
            mag_a_q     <= mag_a_d;
            mag_b_q     <= mag_b_d;
            resp_data_q <= resp_data_d;
        end
    end

    // Outputs: registers, or state decodes gated by flush where it suppresses a pulse
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        md_valid   = (state_q == S_ISSUE) && !flush;
        resp_valid = (state_q == S_DONE) && !flush;
        md_mode    = funct3_q[2];
        md_in_A    = mag_a_q;
        md_in_B    = mag_b_q;
        resp_data  = resp_data_q;
        resp_rd    = rd_q;
        dbg_state  = state_q;
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl: a behavioural multDiv unit, a response monitor
// with an expected queue, table-driven directed vectors, hand-written
// flush/reset sequences and random ops checked against an arithmetic model.
module tb_muldiv_ctrl;
    localparam int RD_W = 5;

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [31:0]     req_rs1;
    logic [31:0]     req_rs2;
    logic [RD_W-1:0] req_rd;
    logic            flush;
    logic            resp_valid;
    logic [31:0]     resp_data;
    logic [RD_W-1:0] resp_rd;
    logic            md_valid;
    logic            md_mode;
    logic [31:0]     md_in_A;
    logic [31:0]     md_in_B;
    logic            md_ready;
    logic [63:0]     md_out;
    logic [2:0]      dbg_state;

    int      n_tests = 0;
    int      n_fail  = 0;
    longint  cyc     = 0;
    int      md_lat  = 33;
    int      mdv_cnt = 0;
    int      resp_cnt = 0;
    longint  resp_cyc = 0;
    logic [31:0] cap_a = '0;
    logic [31:0] cap_b = '0;
    logic        cap_mode = 1'b0;
    logic [RD_W+31:0] exp_q[$];

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    muldiv_ctrl #(.RD_W(RD_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct3 (req_funct3),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_rd     (req_rd),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .md_valid   (md_valid),
        .md_mode    (md_mode),
        .md_in_A    (md_in_A),
        .md_in_B    (md_in_B),
        .md_ready   (md_ready),
        .md_out     (md_out),
        .dbg_state  (dbg_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: RV32M results from signed/unsigned 64-bit arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        int     ia, ib;
        longint sa, sb, ub, sp;
        logic [63:0] p;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        ub = longint'({32'h0, b});
        case (f3)
            3'd0: begin sp = sa * sb; p = sp; return p[31:0]; end
            3'd1: begin sp = sa * sb; p = sp; return p[63:32]; end
            3'd2: begin sp = sa * ub; p = sp; return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                sp = sa / sb;
                p = sp;
                return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                sp = sa % sb;
                p = sp;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] exp_mag(input logic [31:0] x, input bit sgn);
        return (sgn && x[31]) ? (32'd0 - x) : x;
    endfunction

    // Behavioural multDiv unit: fixed latency from md_valid to md_ready
    initial begin : unit_model
        int cnt;
        bit busy;
        cnt = 0;
        busy = 0;
        md_ready = 1'b0;
        md_out = '0;
        forever begin
            @(negedge clk);
            md_ready = 1'b0;
            if (!rst_n) begin
                busy = 0;
            end else begin
                if (busy) begin
                    cnt--;
                    if (cnt == 0) begin
                        busy = 0;
                        check("md_in_A stable", md_in_A, cap_a);
                        check("md_in_B stable", md_in_B, cap_b);
                        if (cap_mode) begin
                            md_out = (cap_b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                  : {cap_a % cap_b, cap_a / cap_b};
                        end else begin
                            md_out = {32'h0, cap_a} * {32'h0, cap_b};
                        end
                        md_ready = 1'b1;
                    end
                end
                if (md_valid) begin
                    if (busy) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL md_valid while busy: got pulse, expected none");
                    end
                    busy = 1;
                    cnt = md_lat;
                    cap_a = md_in_A;
                    cap_b = md_in_B;
                    cap_mode = md_mode;
                    mdv_cnt++;
                end
            end
        end
    end

    // Response monitor / scoreboard
    initial begin : resp_monitor
        logic [RD_W+31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && resp_valid) begin
                resp_cnt++;
                resp_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected resp: got resp_valid data 0x%0h, expected none", resp_data);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_data", {32'h0, resp_data}, {32'h0, e[31:0]});
                    check("resp_rd", {59'h0, resp_rd}, {59'h0, e[RD_W+31:32]});
                end
            end
        end
    end

    // Driver: issue one op and wait for its response
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [RD_W-1:0] rd, input logic [31:0] expd, input string name);
        int w;
        longint acc;
        int r0, m0;
        bit dz, sa, sb;
        w = 0;
        while (!req_ready && w < 200) begin tick(); w++; end
        if (!req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s req_ready timeout: got 0, expected 1", name);
            return;
        end
        dz = f3[2] && (b == 0);
        sa = (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd6);
        sb = (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd6);
        req_valid = 1'b1;
        req_funct3 = f3;
        req_rs1 = a;
        req_rs2 = b;
        req_rd = rd;
        r0 = resp_cnt;
        m0 = mdv_cnt;
        acc = cyc;
        exp_q.push_back({rd, expd});
        tick();
        req_valid = 1'b0;
        req_rs1 = $urandom();
        req_rs2 = $urandom();
        req_funct3 = 3'($urandom_range(7, 0));
        w = 0;
        while (resp_cnt == r0 && w < 200) begin tick(); w++; end
        if (resp_cnt == r0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s resp timeout: got no resp_valid, expected one", name);
            exp_q.delete();
            return;
        end
        check($sformatf("%s latency", name), resp_cyc - acc, dz ? 1 : md_lat + 2);
        check($sformatf("%s md_valid pulses", name), mdv_cnt - m0, dz ? 0 : 1);
        if (!dz) begin
            check($sformatf("%s md_in_A", name), {32'h0, cap_a}, {32'h0, exp_mag(a, sa)});
            check($sformatf("%s md_in_B", name), {32'h0, cap_b}, {32'h0, exp_mag(b, sb)});
            check($sformatf("%s md_mode", name), {63'h0, cap_mode}, {63'h0, f3[2]});
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(5, 0))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(20, 0));
            3: return 32'd0 - 32'($urandom_range(20, 1));
            default: return $urandom();
        endcase
    endfunction

    // Main test sequence
    initial begin : main
        vec_t vecs[16];
        int w, r0, m0;
        bit early;
        bit seen;
        logic [2:0]  f3;
        logic [31:0] a, b;

        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[6]  = '{3'd5, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003};
        vecs[7]  = '{3'd7, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001};
        vecs[8]  = '{3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[9]  = '{3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[12] = '{3'd5, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[13] = '{3'd7, 32'h8765_4321, 32'h0000_0000, 32'h8765_4321};
        vecs[14] = '{3'd0, 32'h0000_0003, 32'h0000_0004, 32'h0000_000C};
        vecs[15] = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};

        rst_n = 1'b0;
        req_valid = 1'b0;
        req_funct3 = 3'd0;
        req_rs1 = '0;
        req_rs2 = '0;
        req_rd = '0;
        flush = 1'b0;
        tick();
        tick();

        // Reset state
        check("reset req_ready", {63'h0, req_ready}, 64'd1);
        check("reset resp_valid", {63'h0, resp_valid}, 64'd0);
        check("reset md_valid", {63'h0, md_valid}, 64'd0);
        check("reset md_mode", {63'h0, md_mode}, 64'd0);
        check("reset md_in_A", {32'h0, md_in_A}, 64'd0);
        check("reset md_in_B", {32'h0, md_in_B}, 64'd0);
        check("reset resp_data", {32'h0, resp_data}, 64'd0);
        check("reset resp_rd", {59'h0, resp_rd}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Directed vectors
        for (int i = 0; i < 16; i++) begin
            do_op(vecs[i].f3, vecs[i].a, vecs[i].b, RD_W'(i + 3), vecs[i].exp,
                  $sformatf("vec%0d", i));
        end

        // Flush 10 cycles after md_valid: drain, no response
        w = 0;
        while (!req_ready && w < 100) begin tick(); w++; end
        r0 = resp_cnt;
        req_valid = 1'b1;
        req_funct3 = 3'd0;
        req_rs1 = 32'd5;
        req_rs2 = 32'd6;
        req_rd = 5'd9;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        early = 0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (md_ready) begin
                seen = 1;
                check("drain req_ready after md_ready", {63'h0, req_ready}, 64'd1);
            end else if (req_ready) begin
                early = 1;
            end
        end
        check("drain md_ready seen", {63'h0, seen}, 64'd1);
        check("drain req_ready held low", {63'h0, early}, 64'd0);
        check("drain no response", resp_cnt - r0, 64'd0);
        do_op(3'd0, 32'd3, 32'd4, 5'd17, 32'd12, "mul after flush");

        // Flush in IDLE blocks a same-cycle request
        m0 = mdv_cnt;
        req_valid = 1'b1;
        req_funct3 = 3'd0;
        req_rs1 = 32'd2;
        req_rs2 = 32'd3;
        flush = 1'b1;
        tick();
        req_valid = 1'b0;
        flush = 1'b0;
        check("idle flush not accepted", {63'h0, req_ready}, 64'd1);
        for (int i = 0; i < 3; i++) tick();
        check("idle flush no md_valid", mdv_cnt - m0, 64'd0);

        // Flush in ISSUE suppresses md_valid
        m0 = mdv_cnt;
        req_valid = 1'b1;
        req_funct3 = 3'd3;
        req_rs1 = 32'd2;
        req_rs2 = 32'd3;
        tick();
        req_valid = 1'b0;
        flush = 1'b1;
        #1;
        check("issue flush md_valid", {63'h0, md_valid}, 64'd0);
        tick();
        flush = 1'b0;
        check("issue flush back to idle", {63'h0, req_ready}, 64'd1);
        for (int i = 0; i < 3; i++) tick();
        check("issue flush no md_valid", mdv_cnt - m0, 64'd0);

        // Flush in DONE suppresses the response
        r0 = resp_cnt;
        req_valid = 1'b1;
        req_funct3 = 3'd4;
        req_rs1 = 32'd5;
        req_rs2 = 32'd0;
        tick();
        req_valid = 1'b0;
        flush = 1'b1;
        #1;
        check("done flush resp_valid", {63'h0, resp_valid}, 64'd0);
        tick();
        flush = 1'b0;
        check("done flush back to idle", {63'h0, req_ready}, 64'd1);
        tick();
        check("done flush no response", resp_cnt - r0, 64'd0);

        // Async reset mid-WAIT
        r0 = resp_cnt;
        req_valid = 1'b1;
        req_funct3 = 3'd4;
        req_rs1 = 32'd1000;
        req_rs2 = 32'd7;
        req_rd = 5'd21;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rst_n = 1'b0;
        #1;
        check("midreset req_ready", {63'h0, req_ready}, 64'd1);
        check("midreset md_valid", {63'h0, md_valid}, 64'd0);
        check("midreset resp_valid", {63'h0, resp_valid}, 64'd0);
        check("midreset md_mode", {63'h0, md_mode}, 64'd0);
        check("midreset md_in_A", {32'h0, md_in_A}, 64'd0);
        check("midreset md_in_B", {32'h0, md_in_B}, 64'd0);
        check("midreset resp_data", {32'h0, resp_data}, 64'd0);
        check("midreset resp_rd", {59'h0, resp_rd}, 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        check("midreset no response", resp_cnt - r0, 64'd0);
        do_op(3'd5, 32'd100, 32'd7, 5'd22, 32'd14, "divu after reset");

        // Random ops against the arithmetic model
        for (int i = 0; i < 60; i++) begin
            md_lat = $urandom_range(36, 1);
            f3 = 3'($urandom_range(7, 0));
            a = pick_operand();
            b = ($urandom_range(7, 0) == 0) ? 32'd0 : pick_operand();
            do_op(f3, a, b, RD_W'($urandom_range(31, 0)), ref_result(f3, a, b),
                  $sformatf("rand%0d f3=%0d a=%h b=%h", i, f3, a, b));
        end

        for (int i = 0; i < 3; i++) tick();
        check("scoreboard empty", exp_q.size(), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
